// File: rtl/top.sv
// Adaptive 4-tap LMS filter demonstrator: an LFSR drives a fixed reference FIR
// (the plant) and an LMS filter that learns the plant's coefficients on-line.
module top #(
  parameter int          DW        = 16,
  parameter int          FRAC      = 8,
  parameter int          MU_SHIFT  = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          H0        = 256,
  parameter int          H1        = -128,
  parameter int          H2        = 64,
  parameter int          H3        = 32
) (
  input logic clk,
  input logic rst
);

  localparam int PW = 2 * DW;
  localparam int SW = PW + 2;

  localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [SW-1:0] WMAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] WMIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic [15:0]          lfsr;
  logic signed [DW-1:0] xdl     [0:3];
  logic signed [DW-1:0] weights [0:3];
  logic signed [DW-1:0] wnext   [0:3];

  logic signed [DW-1:0] x_in;
  logic signed [DW-1:0] d_in;
  logic signed [DW-1:0] y_out;
  logic signed [DW-1:0] e_out;

  logic signed [SW-1:0] dsum;
  logic signed [SW-1:0] ysum;

  function automatic logic signed [DW-1:0] coef(input int k);
    case (k)
      0:       coef = DW'(H0);
      1:       coef = DW'(H1);
      2:       coef = DW'(H2);
      default: coef = DW'(H3);
    endcase
  endfunction

  // Operands are widened before multiplying so the full product is kept.
  function automatic logic signed [PW-1:0] mul(input logic signed [DW-1:0] a,
                                              input logic signed [DW-1:0] b);
    mul = PW'(a) * PW'(b);
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > WMAX) begin
      sat = SMAX;
    end else if (v < WMIN) begin
      sat = SMIN;
    end else begin
      sat = v[DW-1:0];
    end
  endfunction

  always_comb begin
    dsum = '0;
    ysum = '0;
    for (int k = 0; k < 4; k++) begin
      dsum = dsum + SW'(mul(coef(k), xdl[k]));
      ysum = ysum + SW'(mul(weights[k], xdl[k]));
    end
    x_in  = xdl[0];
    d_in  = sat(dsum >>> FRAC);
    y_out = sat(ysum >>> FRAC);
    e_out = sat(SW'(d_in) - SW'(y_out));
  end

  // Weight update uses the error and taps as they stand before the edge.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      wnext[k] = sat(SW'(weights[k]) + SW'(mul(e_out, xdl[k]) >>> MU_SHIFT));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= LFSR_SEED;
      for (int k = 0; k < 4; k++) begin
        xdl[k]     <= '0;
        weights[k] <= '0;
      end
    end else begin
      lfsr   <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      xdl[0] <= {{(DW-8){lfsr[7]}}, lfsr[7:0]};
      for (int k = 1; k < 4; k++) begin
        xdl[k] <= xdl[k-1];
      end
      for (int k = 0; k < 4; k++) begin
        weights[k] <= wnext[k];
      end
    end
  end

endmodule

// File: tb/tb_top.sv
// Bench for the LMS demonstrator: reference model of LFSR, plant and LMS in plain
// integer arithmetic, scoreboard queues, random reset timing, directed spot checks.
module tb_top;

  localparam int FRAC    = 8;
  localparam int MU_DEF  = 8;
  localparam int MU_FAST = 0;
  localparam int TOL_W   = 32;
  localparam int TOL_E   = 32;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_q[$];
  logic [127:0] exp_f_q[$];

  int m_lf, t_lf, f_lf, u_lf;
  int m_xd[4], t_xd[4], f_xd[4], u_xd[4];
  int m_w[4], t_w[4], f_w[4], u_w[4];
  int md, my, me, fd, fy, fe;
  bit fast_sat_seen = 0;
  int max_abs_e;

  top dut (
    .clk(clk),
    .rst(rst)
  );

  top #(.MU_SHIFT(MU_FAST)) dut_fast (
    .clk(clk),
    .rst(rst)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic int h_coef(input int k);
    case (k)
      0:       return 256;
      1:       return -128;
      2:       return 64;
      default: return 32;
    endcase
  endfunction

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Division by 2^sh rounding toward minus infinity.
  function automatic longint floor_div(input longint v, input int sh);
    longint p = 1;
    for (int i = 0; i < sh; i++) p = p * 2;
    if (v >= 0) return v / p;
    return -((-v + p - 1) / p);
  endfunction

  function automatic void model_eval(input int xd[4], input int w[4],
                                     output int d, output int y, output int e);
    longint sd = 0;
    longint sy = 0;
    for (int k = 0; k < 4; k++) begin
      sd += longint'(h_coef(k)) * xd[k];
      sy += longint'(w[k]) * xd[k];
    end
    d = sat16(floor_div(sd, FRAC));
    y = sat16(floor_div(sy, FRAC));
    e = sat16(longint'(d) - y);
  endfunction

  function automatic void model_step(input logic r, input int mu, input int lf,
                                     input int xd[4], input int w[4],
                                     output int lf_n, output int xd_n[4], output int w_n[4]);
    int d, y, e, s;
    if (!r) begin
      lf_n = 'hACE1;
      for (int k = 0; k < 4; k++) begin
        xd_n[k] = 0;
        w_n[k]  = 0;
      end
      return;
    end
    model_eval(xd, w, d, y, e);
    for (int k = 0; k < 4; k++) begin
      w_n[k] = sat16(longint'(w[k]) + floor_div(longint'(e) * xd[k], mu));
    end
    s = lf % 256;
    if (s >= 128) s -= 256;
    xd_n[0] = s;
    xd_n[1] = xd[0];
    xd_n[2] = xd[1];
    xd_n[3] = xd[2];
    lf_n = (lf % 2 == 1) ? ((lf / 2) ^ 'hB400) : (lf / 2);
  endfunction

  function automatic logic [127:0] pack(input int x, input int d, input int y,
                                        input int e, input int w[4]);
    return {16'(x), 16'(d), 16'(y), 16'(e), 16'(w[0]), 16'(w[1]), 16'(w[2]), 16'(w[3])};
  endfunction

  function automatic string field_name(input int i);
    case (i)
      0:       return "x_in";
      1:       return "d_in";
      2:       return "y_out";
      3:       return "e_out";
      4:       return "w0";
      5:       return "w1";
      6:       return "w2";
      default: return "w3";
    endcase
  endfunction

  // ---------------- checkers ----------------
  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, $signed(act), $signed(exp), $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  task automatic compare_all(input string tag, input logic [127:0] act, input logic [127:0] exp);
    for (int i = 0; i < 8; i++) begin
      check16({tag, field_name(i)}, act[127-16*i -: 16], exp[127-16*i -: 16]);
    end
  endtask

  task automatic check_cleared();
    compare_all("async_rst ",
                {dut.x_in, dut.d_in, dut.y_out, dut.e_out,
                 dut.weights[0], dut.weights[1], dut.weights[2], dut.weights[3]}, '0);
    compare_all("async_rst_mu0 ",
                {dut_fast.x_in, dut_fast.d_in, dut_fast.y_out, dut_fast.e_out,
                 dut_fast.weights[0], dut_fast.weights[1], dut_fast.weights[2],
                 dut_fast.weights[3]}, '0);
  endtask

  // ---------------- model processes: push expected post-edge state ----------------
  initial forever begin
    @(posedge clk);
    model_step(rst, MU_DEF, m_lf, m_xd, m_w, t_lf, t_xd, t_w);
    m_lf = t_lf;
    m_xd = t_xd;
    m_w  = t_w;
    model_eval(m_xd, m_w, md, my, me);
    exp_q.push_back(pack(m_xd[0], md, my, me, m_w));
  end

  initial forever begin
    @(posedge clk);
    model_step(rst, MU_FAST, f_lf, f_xd, f_w, u_lf, u_xd, u_w);
    f_lf = u_lf;
    f_xd = u_xd;
    f_w  = u_w;
    model_eval(f_xd, f_w, fd, fy, fe);
    exp_f_q.push_back(pack(f_xd[0], fd, fy, fe, f_w));
  end

  // ---------------- monitors: pop and compare away from the active edge ----------------
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      compare_all("sb ",
                  {dut.x_in, dut.d_in, dut.y_out, dut.e_out,
                   dut.weights[0], dut.weights[1], dut.weights[2], dut.weights[3]},
                  exp_q.pop_front());
    end
  end

  initial forever begin
    @(negedge clk);
    if (exp_f_q.size() > 0) begin
      compare_all("sb_mu0 ",
                  {dut_fast.x_in, dut_fast.d_in, dut_fast.y_out, dut_fast.e_out,
                   dut_fast.weights[0], dut_fast.weights[1], dut_fast.weights[2],
                   dut_fast.weights[3]},
                  exp_f_q.pop_front());
    end
    for (int k = 0; k < 4; k++) begin
      if (dut_fast.weights[k] == 16'sh7FFF || dut_fast.weights[k] == 16'sh8000)
        fast_sat_seen = 1'b1;
    end
  end

  // ---------------- driver ----------------
  task automatic release_and_check_start(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check16({tag, " x_in"}, dut.x_in, 16'hFFE1);
    check16({tag, " d_in"}, dut.d_in, 16'hFFE1);
    check16({tag, " y_out"}, dut.y_out, 16'h0000);
    check16({tag, " e_out"}, dut.e_out, 16'hFFE1);
    check16({tag, " w0_first"}, dut.weights[0], 16'h0000);
    @(negedge clk);
    check16({tag, " w0_second"}, dut.weights[0], 16'd3);
    check16({tag, " w1_second"}, dut.weights[1], 16'd0);
    check16({tag, " w3_second"}, dut.weights[3], 16'd0);
    check16({tag, " x_second"}, dut.x_in, 16'd112);
  endtask

  task automatic pulse_reset(input int cycles);
    #($urandom_range(1, 3)) rst = 1'b0;
    #1 check_cleared();
    repeat (cycles) @(negedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    #1 check_cleared();
    repeat (2) @(posedge clk);
    release_and_check_start("start");

    repeat (497) @(negedge clk);
    pulse_reset(1);
    rst = 1'b0;
    release_and_check_start("restart");

    // Floor rounding in the update leaves the steady-state weights a few LSB
    // below the plant, so convergence is checked against a band.
    repeat (1900) @(negedge clk);
    max_abs_e = 0;
    repeat (100) begin
      @(negedge clk);
      if ($signed(dut.e_out) > max_abs_e) max_abs_e = $signed(dut.e_out);
      if (-$signed(dut.e_out) > max_abs_e) max_abs_e = -$signed(dut.e_out);
    end
    check_range("conv_max_abs_e", max_abs_e, 0, TOL_E);
    for (int k = 0; k < 4; k++) begin
      check_range($sformatf("conv_w%0d", k), int'($signed(dut.weights[k])),
                  h_coef(k) - TOL_W, h_coef(k) + TOL_W);
    end

    repeat (3) begin
      repeat ($urandom_range(20, 200)) @(negedge clk);
      pulse_reset($urandom_range(1, 3));
    end

    repeat (50) @(negedge clk);
    #2;
    check_range("sb_drain", exp_q.size(), 0, 0);
    check_range("sb_mu0_drain", exp_f_q.size(), 0, 0);
    check_range("mu0_sat_seen", int'(fast_sat_seen), 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
